// File: rtl/corr_sched_pkg.sv
// Shared constants and FSM state type for the stereo correlator line scheduler.
// Array geometry and pulse timing live here so RTL and bench agree on them.
package corr_sched_pkg;
  localparam int NUM_DISP         = 11;
  localparam int SCORE_W          = 16;
  localparam int DISP_W           = 4;
  localparam logic [DISP_W-1:0] DISP_REJECT = 4'hF;
  localparam int LINE_W           = 64;
  localparam int PIPE_DEPTH       = 3;
  localparam int WEN_GAP          = 3;
  localparam int FILL_PULSES      = NUM_DISP - 1 + PIPE_DEPTH;
  localparam int TOTAL_PULSES     = LINE_W + PIPE_DEPTH;
  localparam int RESULTS_PER_LINE = LINE_W - NUM_DISP + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } sched_state_t;
endpackage

// File: rtl/corr_line_sched_if.sv
// Sample stream, array port and result stream of the correlator line scheduler.
// master = scheduler side, slave = surrounding datapath / testbench.
interface corr_line_sched_if;
  import corr_sched_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  logic [7:0]                   in_l_1;
  logic [7:0]                   in_l_2;
  logic [7:0]                   in_r_1;
  logic [7:0]                   in_r_2;
  logic                         arr_wen;
  logic [7:0]                   arr_l_1;
  logic [7:0]                   arr_l_2;
  logic [7:0]                   arr_r_1;
  logic [7:0]                   arr_r_2;
  logic [NUM_DISP*SCORE_W-1:0]  arr_corr;
  logic                         res_valid;
  logic                         res_ready;
  logic [DISP_W-1:0]            res_disp;
  logic [SCORE_W-1:0]           res_score;
  logic                         res_last;

  modport master (
    input  in_valid, in_l_1, in_l_2, in_r_1, in_r_2, arr_corr, res_ready,
    output in_ready, arr_wen, arr_l_1, arr_l_2, arr_r_1, arr_r_2,
           res_valid, res_disp, res_score, res_last
  );

  modport slave (
    output in_valid, in_l_1, in_l_2, in_r_1, in_r_2, arr_corr, res_ready,
    input  in_ready, arr_wen, arr_l_1, arr_l_2, arr_r_1, arr_r_2,
           res_valid, res_disp, res_score, res_last
  );
endinterface

// File: rtl/corr_argmax.sv
// Combinational NUM_DISP-way max/argmax over packed correlation scores.
// Unsigned compare, strict greater-than so ties resolve to the lowest tap.
module corr_argmax
  import corr_sched_pkg::*;
(
  input  logic [NUM_DISP*SCORE_W-1:0] corr,
  output logic [DISP_W-1:0]           best_idx,
  output logic [SCORE_W-1:0]          best_score
);
  logic [SCORE_W-1:0] tap [NUM_DISP];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DISP; gi++) begin : g_tap
      assign tap[gi] = corr[gi*SCORE_W +: SCORE_W];
    end
  endgenerate

  always_comb begin
    best_score = tap[0];
    best_idx   = '0;
    for (int k = 1; k < NUM_DISP; k++) begin
      if (tap[k] > best_score) begin
        best_score = tap[k];
        best_idx   = DISP_W'(k);
      end
    end
  end
endmodule

// File: rtl/corr_line_sched.sv
// Line scheduler: feeds the correlator array with spaced arr_wen pulses, drains it with
// zero samples and reduces valid score vectors to a result stream. Macro: CORR_THRESH_EN.
module corr_line_sched
  import corr_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
`ifdef CORR_THRESH_EN
  input  logic [SCORE_W-1:0]  cfg_thresh,
`endif
  corr_line_sched_if.master   bus
);
  localparam int P_W = $clog2(TOTAL_PULSES + 1);
  localparam int G_W = $clog2(WEN_GAP);

  sched_state_t       state_reg;
  logic               busy_reg;
  logic [P_W-1:0]     pulse_cnt_reg;
  logic [G_W-1:0]     gap_cnt_reg;
  logic               cap_pend_reg;
  logic               cap_last_reg;
  logic               arr_wen_reg;
  logic [7:0]         arr_l_1_reg, arr_l_2_reg, arr_r_1_reg, arr_r_2_reg;
  logic               res_valid_reg;
  logic [DISP_W-1:0]  res_disp_reg;
  logic [SCORE_W-1:0] res_score_reg;
  logic               res_last_reg;

  logic [DISP_W-1:0]  best_idx;
  logic [SCORE_W-1:0] best_score;
  logic [DISP_W-1:0]  disp_sel;
  logic [P_W-1:0]     pulse_next;
  logic               cap_ok_next, cap_last_next;
  logic               feeding, out_free, slot_free, issue, capture;

  corr_argmax u_argmax (
    .corr       (bus.arr_corr),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

`ifdef CORR_THRESH_EN
  assign disp_sel = (best_score < cfg_thresh) ? DISP_REJECT : best_idx;
`else
  assign disp_sel = best_idx;
`endif

  // A pulse or capture may only proceed when the output register can take a new result.
  assign feeding   = (state_reg == ST_FILL) || (state_reg == ST_RUN);
  assign out_free  = !res_valid_reg || bus.res_ready;
  assign slot_free = (gap_cnt_reg == '0) && out_free;
  assign issue     = (feeding && bus.in_valid && slot_free) || ((state_reg == ST_DRAIN) && slot_free);
  assign capture   = cap_pend_reg && slot_free;

  assign pulse_next    = pulse_cnt_reg + 1'b1;
  assign cap_ok_next   = (pulse_next >= P_W'(NUM_DISP + PIPE_DEPTH)) &&
                         (pulse_next <= P_W'(TOTAL_PULSES));
  assign cap_last_next = (pulse_next == P_W'(TOTAL_PULSES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      pulse_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      cap_pend_reg  <= 1'b0;
      cap_last_reg  <= 1'b0;
    end else begin
      if (issue) begin
        gap_cnt_reg   <= G_W'(WEN_GAP - 1);
        pulse_cnt_reg <= pulse_next;
        cap_pend_reg  <= cap_ok_next;
        cap_last_reg  <= cap_last_next;
      end else begin
        if (gap_cnt_reg != '0) gap_cnt_reg <= gap_cnt_reg - 1'b1;
        if (capture) cap_pend_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_FILL;
            busy_reg      <= 1'b1;
            pulse_cnt_reg <= '0;
          end
        end
        ST_FILL, ST_RUN: begin
          if (issue) begin
            if (pulse_next == P_W'(LINE_W))           state_reg <= ST_DRAIN;
            else if (pulse_next == P_W'(FILL_PULSES)) state_reg <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (issue && (pulse_next == P_W'(TOTAL_PULSES))) state_reg <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!cap_pend_reg && res_valid_reg && res_last_reg && bus.res_ready) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port and result register; drain pulses carry zero samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_wen_reg   <= 1'b0;
      arr_l_1_reg   <= '0;
      arr_l_2_reg   <= '0;
      arr_r_1_reg   <= '0;
      arr_r_2_reg   <= '0;
      res_valid_reg <= 1'b0;
      res_disp_reg  <= '0;
      res_score_reg <= '0;
      res_last_reg  <= 1'b0;
    end else begin
      arr_wen_reg <= issue;
      if (issue) begin
        arr_l_1_reg <= feeding ? bus.in_l_1 : 8'h00;
        arr_l_2_reg <= feeding ? bus.in_l_2 : 8'h00;
        arr_r_1_reg <= feeding ? bus.in_r_1 : 8'h00;
        arr_r_2_reg <= feeding ? bus.in_r_2 : 8'h00;
      end
      if (capture) begin
        res_valid_reg <= 1'b1;
        res_disp_reg  <= disp_sel;
        res_score_reg <= best_score;
        res_last_reg  <= cap_last_reg;
      end else if (bus.res_ready) begin
        res_valid_reg <= 1'b0;
        res_last_reg  <= 1'b0;
      end
    end
  end

  assign busy          = busy_reg;
  assign bus.in_ready  = feeding && slot_free;
  assign bus.arr_wen   = arr_wen_reg;
  assign bus.arr_l_1   = arr_l_1_reg;
  assign bus.arr_l_2   = arr_l_2_reg;
  assign bus.arr_r_1   = arr_r_1_reg;
  assign bus.arr_r_2   = arr_r_2_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_disp  = res_disp_reg;
  assign bus.res_score = res_score_reg;
  assign bus.res_last  = res_last_reg;
endmodule

// File: tb/tb_corr_line_sched.sv
// Directed bench for corr_line_sched: full lines, backpressure, ties, async reset mid-line.
// With CORR_THRESH_EN defined it also exercises the rejection threshold.
module tb_corr_line_sched;
  import corr_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
`ifdef CORR_THRESH_EN
  logic [SCORE_W-1:0] cfg_thresh;
`endif

  int n_checks;
  int n_fail;

  always #5 clk = ~clk;

  corr_line_sched_if bus ();

  corr_line_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
`ifdef CORR_THRESH_EN
    .cfg_thresh (cfg_thresh),
`endif
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_sample(input int s);
    logic [7:0] b;
    b = 8'(s);
    bus.in_l_1 = b;
    bus.in_l_2 = ~b;
    bus.in_r_1 = b ^ 8'hA5;
    bus.in_r_2 = b + 8'h40;
  endtask

  function automatic logic [31:0] exp_arr(input int n);
    logic [7:0] b;
    b = 8'(n);
    if (n > LINE_W) return 32'd0;
    return {b, ~b, b ^ 8'hA5, b + 8'h40};
  endfunction

  // Score of tap k = base + step*k, except taps hi_a/hi_b which get hi_val.
  task automatic load_scores(input logic [15:0] base, input logic [15:0] step,
                             input int hi_a, input int hi_b, input logic [15:0] hi_val);
    for (int k = 0; k < NUM_DISP; k++) begin
      bus.arr_corr[k*SCORE_W +: SCORE_W] = (k == hi_a || k == hi_b) ? hi_val : base + 16'(k) * step;
    end
  endtask

  task automatic run_line(input string name, input logic [3:0] exp_disp, input logic [15:0] exp_score,
                          input bit exact_gap, input int stall_at, input int abort_at);
    int pulses, results, sample, last_cyc, stall_left;
    bit done, advance, stall_done, stalled_now;
    logic [3:0]  held_disp;
    logic [15:0] held_score;
    pulses = 0; results = 0; sample = 1; last_cyc = 0; stall_left = 0;
    done = 1'b0; advance = 1'b0; stall_done = 1'b0;
    held_disp = '0; held_score = '0;

    @(negedge clk);
    drive_sample(sample);
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    start = 1'b1;
    #1;
    check_eq({name, " in_ready_idle"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq({name, " busy_rise"}, 32'(busy), 32'd1);

    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (bus.arr_wen) begin
        pulses++;
        check_eq({name, " arr_data"}, {bus.arr_l_1, bus.arr_l_2, bus.arr_r_1, bus.arr_r_2}, exp_arr(pulses));
        if (pulses > 1) begin
          if (exact_gap) check_eq({name, " wen_gap"}, 32'(cyc - last_cyc), 32'(WEN_GAP));
          else           check_eq({name, " wen_gap_min"}, 32'((cyc - last_cyc) >= WEN_GAP), 32'd1);
        end
        last_cyc = cyc;
      end
      if (!busy) begin
        done = 1'b1;
        bus.in_valid = 1'b0;
        check_eq({name, " result_count"}, 32'(results), 32'(RESULTS_PER_LINE));
        check_eq({name, " pulse_count"}, 32'(pulses), 32'(TOTAL_PULSES));
        check_eq({name, " res_valid_after"}, 32'(bus.res_valid), 32'd0);
      end else begin
        if (advance) begin
          sample++;
          advance = 1'b0;
          if (sample > LINE_W) bus.in_valid = 1'b0;
          else drive_sample(sample);
        end
        start = (pulses == 30);
        if (!stall_done && stall_at > 0 && results == stall_at && bus.res_valid) begin
          stall_left = 20;
          stall_done = 1'b1;
          held_disp  = bus.res_disp;
          held_score = bus.res_score;
        end
        stalled_now = (stall_left > 0);
        if (stalled_now) begin
          bus.res_ready = 1'b0;
          check_eq({name, " stall_valid"}, 32'(bus.res_valid), 32'd1);
          check_eq({name, " stall_held"}, {12'd0, bus.res_disp, bus.res_score}, {12'd0, held_disp, held_score});
          if (stall_left < 20) check_eq({name, " stall_no_wen"}, 32'(bus.arr_wen), 32'd0);
          stall_left--;
        end else begin
          bus.res_ready = 1'b1;
        end
        #1;
        if (stalled_now) check_eq({name, " stall_in_ready"}, 32'(bus.in_ready), 32'd0);
        if (bus.in_valid && bus.in_ready) advance = 1'b1;
        if (bus.res_valid && bus.res_ready) begin
          results++;
          $display("%s result %0d disp %0d score 0x%04h last %0b",
                   name, results, bus.res_disp, bus.res_score, bus.res_last);
          check_eq({name, " res_disp"}, 32'(bus.res_disp), 32'(exp_disp));
          check_eq({name, " res_score"}, 32'(bus.res_score), 32'(exp_score));
          check_eq({name, " res_last"}, 32'(bus.res_last), 32'(results == RESULTS_PER_LINE));
          if (abort_at > 0 && results == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_eq({name, " rst_flags"},
                     32'({busy, bus.in_ready, bus.arr_wen, bus.res_valid, bus.res_last}), 32'd0);
            check_eq({name, " rst_arr_data"}, {bus.arr_l_1, bus.arr_l_2, bus.arr_r_1, bus.arr_r_2}, 32'd0);
            check_eq({name, " rst_result"}, {12'd0, bus.res_disp, bus.res_score}, 32'd0);
            done = 1'b1;
          end
        end
      end
    end
    start = 1'b0;
    check_eq({name, " finished"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [3:0] zero_disp;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.arr_corr  = '0;
    drive_sample(0);
`ifdef CORR_THRESH_EN
    cfg_thresh = 16'h0100;
    zero_disp  = 4'hF;
`else
    zero_disp  = 4'h0;
`endif
    repeat (3) @(negedge clk);
    check_eq("reset flags", 32'({busy, bus.in_ready, bus.arr_wen, bus.res_valid, bus.res_last}), 32'd0);
    check_eq("reset arr_data", {bus.arr_l_1, bus.arr_l_2, bus.arr_r_1, bus.arr_r_2}, 32'd0);
    check_eq("reset result", {12'd0, bus.res_disp, bus.res_score}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle busy", 32'(busy), 32'd0);

    load_scores(16'h0010, 16'h0001, 3, 3, 16'h0800);
    run_line("tap3", 4'd3, 16'h0800, 1'b1, 0, 0);

    load_scores(16'h0100, 16'h0010, 2, 7, 16'h1234);
    run_line("tie", 4'd2, 16'h1234, 1'b0, 20, 0);

    load_scores(16'h0010, 16'h0001, 3, 3, 16'h0800);
    run_line("abort", 4'd3, 16'h0800, 1'b1, 0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    run_line("restart", 4'd3, 16'h0800, 1'b1, 0, 0);

    load_scores(16'h0000, 16'h0000, -1, -1, 16'h0000);
    run_line("zero", zero_disp, 16'h0000, 1'b1, 0, 0);

`ifdef CORR_THRESH_EN
    load_scores(16'h0010, 16'h0001, 5, 5, 16'h00FF);
    run_line("thr_below", 4'hF, 16'h00FF, 1'b1, 0, 0);
    load_scores(16'h0010, 16'h0001, 5, 5, 16'h0100);
    run_line("thr_equal", 4'd5, 16'h0100, 1'b1, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
